fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Consumer-side companion to the R2^2 SDF FFT core. The core emits each 256-point frame, scaled 1/N, in bit-reversed order on a di_en/re/im stream with no backpressure.
- This block captures each frame into a ping-pong buffer and replays it in natural bin order on a valid/ready stream, with a bin index.
- Downstream spectral logic (magnitude, peak detect) reads bins 0..N-1 in order.

Parameters:
- WIDTH, 32, bit width of each real/imag sample.
- LOG2N, 8, log2 of frame length; N = 2^LOG2N = 256.

Ports:
- clock  in  1  master clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- di_en  in  1  input sample valid (FFT do_en); no backpressure toward the FFT
- di_re  in  WIDTH  input real, bit-reversed order
- di_im  in  WIDTH  input imag, bit-reversed order
- do_en  out  1  output valid
- do_ready  in  1  downstream ready
- do_re  out  WIDTH  output real, natural order
- do_im  out  WIDTH  output imag, natural order
- do_idx  out  LOG2N  bin index of current output sample
- do_last  out  1  high with bin N-1
- ovf  out  1  sticky overflow: at least one input frame was dropped
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Storage: two banks (A, B) of N x 2*WIDTH. Each bank has state EMPTY, FILLING, FULL or READING.
- Write side:
  - wr_cnt (LOG2N bits) counts accepted samples within the frame.
  - Sample j is written at address bitrev(j) of the current write bank. wr_cnt increments only on di_en, so gaps in di_en are allowed.
  - When wr_cnt wraps from N-1 to 0, the write bank goes FILLING->FULL and the write bank toggles.
- Frame start (di_en with wr_cnt=0):
  - If the target bank is EMPTY it becomes FILLING.
  - Otherwise the block enters DROP: all N samples of that frame are counted but not written, ovf is set, and the bank pointer does not toggle at the end of the frame.
  - Frame alignment is always kept by wr_cnt.
- Read side:
  - The read pointer starts at bank A.
  - When the read bank is FULL it becomes READING. rd_cnt runs 0..N-1, advancing on each do_en && do_ready.
  - The output at rd_cnt=k is do_re/do_im = mem[k], do_idx=k, do_last=(k==N-1).
  - After the handshake with do_last, the bank goes to EMPTY and the read pointer toggles.
- Output stream rules:
  - do_re/do_im/do_idx/do_last are held stable while do_en && !do_ready.
  - do_en never drops mid-frame while do_ready=1.
  - With do_ready held high, output runs N consecutive cycles per frame with no bubbles, and back-to-back frames are also gap-free.
  - Memory read latency is hidden by a prefetch/skid register.
- Latency: with do_ready=1, do_en first rises 2 clock cycles after the edge that accepts input sample N-1 of the frame.
- Throughput: sustains continuous input (one sample per clock, consecutive frames) with do_ready=1 and no drops.
- Simultaneous events:
  - A bank transitioning READING->EMPTY in the same cycle a new frame starts into it counts as EMPTY; the frame is accepted.
  - ovf_clr and a new drop in the same cycle leave ovf=1.
- Reset values (all outputs):
  - do_en=0, do_re=0, do_im=0, do_idx=0, do_last=0, ovf=0.
  - Both banks EMPTY, wr_cnt=rd_cnt=0, both pointers at bank A, DROP cleared.
- Reset mid-frame: any partial input frame and any frame being read are discarded. After release, the next di_en is treated as sample 0.
- Memory contents are not reset.

Test Plan:
- Single frame: di_en=1 for 256 cycles with di_re=bitrev8(j), di_im=~bitrev8(j); do_ready=1 -> do_re=0..255 in order, do_idx=do_re, do_im=~do_idx, do_last only at 255, first do_en 2 cycles after the last input.
- Continuous: 4 back-to-back frames with frame tag in di_im[31:24] -> 1024 consecutive do_en cycles, tags 0,1,2,3 in order, ovf=0.
- Gaps and backpressure: di_en 50% random, do_ready random 30% low -> natural order preserved, outputs stable while stalled, no loss.
- Overflow: do_ready=0, feed frames 0,1,2 -> frame 2 dropped, ovf=1. Then do_ready=1 -> frames 0 and 1 output. Frame 3 is accepted and output with correct data. ovf_clr -> ovf=0.
- Reset mid-operation: assert reset_n=0 at input sample 100 and during output bin 40 -> do_en=0 immediately (async). The next full frame after release is output cleanly from bin 0.
- Boundary: frame start coinciding with the do_last handshake of the same bank -> frame accepted, ovf stays 0.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Captures bit-reversed FFT frames into a two-bank ping-pong buffer and replays
// them in natural bin order on a valid/ready stream with bin index and last flag.
module fft_bitrev_reorder #(
    parameter int WIDTH = 32,
    parameter int LOG2N = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    input  logic             do_ready,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG2N-1:0] do_idx,
    output logic             do_last,
    output logic             ovf,
    input  logic             ovf_clr
);
    localparam int N = 1 << LOG2N;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_st_t;

    logic [2*WIDTH-1:0] mem [2*N];

    bank_st_t   bank_st [2];
    bank_st_t   bank_nx [2];
    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic       wr_bank, rd_bank, drop;

    logic       o_adv, rd_avail, issue, rel;
    logic       frame_start, start_ok, wr_en, frame_end;

    logic             f_valid;
    logic [LOG2N-1:0] f_idx;
    logic [2*WIDTH-1:0] f_data;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = {<<{v}};
        return r;
    endfunction

    // The bank is released as soon as its last word has been fetched into the
    // prefetch stage; the remaining words live in registers, which is what keeps
    // back-to-back frames from colliding with the writer.
    always_comb begin
        o_adv       = !do_en || do_ready;
        rd_avail    = (bank_st[rd_bank] == FULL) || (bank_st[rd_bank] == READING);
        issue       = rd_avail && (!f_valid || o_adv);
        rel         = issue && (rd_cnt == '1);
        frame_start = di_en && (wr_cnt == '0);
        start_ok    = (bank_st[wr_bank] == EMPTY) || (rel && (rd_bank == wr_bank));
        wr_en       = di_en && (frame_start ? start_ok : !drop);
        frame_end   = di_en && (wr_cnt == '1) && !drop;
    end

    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            bank_nx[b] = bank_st[b];
            if (issue && (rd_bank == 1'(b)))
                bank_nx[b] = rel ? EMPTY : READING;
            if (frame_start && start_ok && (wr_bank == 1'(b)))
                bank_nx[b] = FILLING;
            if (frame_end && (wr_bank == 1'(b)))
                bank_nx[b] = FULL;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < 2; b++) bank_st[b] <= EMPTY;
        end else begin
            for (int unsigned b = 0; b < 2; b++) bank_st[b] <= bank_nx[b];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            drop    <= 1'b0;
            ovf     <= 1'b0;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (di_en) wr_cnt <= wr_cnt + LOG2N'(1);
            if (frame_start) drop <= !start_ok;
            if (frame_end) wr_bank <= ~wr_bank;
            if (frame_start && !start_ok) ovf <= 1'b1;
            else if (ovf_clr)             ovf <= 1'b0;
            if (issue) rd_cnt <= rd_cnt + LOG2N'(1);
            if (rel)   rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[{wr_bank, bitrev(wr_cnt)}] <= {di_re, di_im};
        if (issue) f_data <= mem[{rd_bank, rd_cnt}];
    end

    // Two-stage read pipe: prefetch register feeding the output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f_valid <= 1'b0;
            f_idx   <= '0;
            do_en   <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
            do_idx  <= '0;
            do_last <= 1'b0;
        end else begin
            if (issue) begin
                f_valid <= 1'b1;
                f_idx   <= rd_cnt;
            end else if (o_adv) begin
                f_valid <= 1'b0;
            end
            if (o_adv) begin
                do_en <= f_valid;
                if (f_valid) begin
                    do_re   <= f_data[2*WIDTH-1:WIDTH];
                    do_im   <= f_data[WIDTH-1:0];
                    do_idx  <= f_idx;
                    do_last <= (f_idx == '1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-level model of expected natural-order
// outputs, checked every output-valid cycle, plus literal pins and scenarios.
module tb_fft_bitrev_reorder;
    localparam int WIDTH = 32;
    localparam int LOG2N = 8;
    localparam int N     = 256;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = '0;
    logic [WIDTH-1:0] di_im = '0;
    logic             do_en;
    logic             do_ready;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic [LOG2N-1:0] do_idx;
    logic             do_last;
    logic             ovf;
    logic             ovf_clr = 1'b0;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;
    int cur_run = 0;
    int max_run = 0;

    always #5 clock = ~clock;

    fft_bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clock(clock), .reset_n(reset_n),
        .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en), .do_ready(do_ready),
        .do_re(do_re), .do_im(do_im), .do_idx(do_idx), .do_last(do_last),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bit reversal by repeated halving, independent of any bit slicing.
    function automatic int model_rev(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] tag, input bit gaps, input bit accept,
                              input bit clr_at_start);
        logic [31:0] sre [N];
        logic [31:0] sim [N];
        logic [7:0]  b;
        for (int j = 0; j < N; j++) begin
            if (gaps) begin
                int g = 0;
                while (g < 8 && $urandom_range(0, 1) == 1) begin
                    di_en = 1'b0;
                    ovf_clr = 1'b0;
                    @(posedge clock); #1;
                    g++;
                end
            end
            b = 8'(model_rev(j));
            sre[j] = {24'h0, b};
            sim[j] = {tag, 16'hFFFF, ~b};
            di_en = 1'b1;
            di_re = sre[j];
            di_im = sim[j];
            ovf_clr = clr_at_start && (j == 0);
            @(posedge clock); #1;
        end
        di_en = 1'b0;
        ovf_clr = 1'b0;
        if (accept)
            for (int k = 0; k < N; k++)
                q.push_back('{re: sre[model_rev(k)], im: sim[model_rev(k)],
                              idx: 8'(k), last: (k == N - 1)});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || do_en) && n < 4000) begin
            @(negedge clock); #1;
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic apply_reset(input string name);
        reset_n = 1'b0;
        di_en = 1'b0;
        #1;
        chk({name, "_do_en"}, do_en, 0);
        chk({name, "_do_re"}, do_re, 0);
        chk({name, "_do_im"}, do_im, 0);
        chk({name, "_do_idx"}, do_idx, 0);
        chk({name, "_do_last"}, do_last, 0);
        chk({name, "_ovf"}, ovf, 0);
        q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        do_ready = 1'b0;
        forever begin
            @(posedge clock); #2;
            case (rdy_mode)
                0:       do_ready = 1'b0;
                1:       do_ready = 1'b1;
                default: do_ready = ($urandom_range(0, 99) >= 30);
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (do_en) begin
                    cur_run++;
                    if (cur_run > max_run) max_run = cur_run;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual idx=%0d re=%h required no output",
                                 do_idx, do_re);
                    end else begin
                        e = q[0];
                        checks++;
                        if ({do_re, do_im, do_idx, do_last} !== {e.re, e.im, e.idx, e.last}) begin
                            failures++;
                            $display("FAIL stream actual re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d last=%b",
                                     do_re, do_im, do_idx, do_last, e.re, e.im, e.idx, e.last);
                        end
                        if (do_ready) void'(q.pop_front());
                    end
                end else begin
                    cur_run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("reset_do_en", do_en, 0);
        chk("reset_do_re", do_re, 0);
        chk("reset_do_im", do_im, 0);
        chk("reset_do_idx", do_idx, 0);
        chk("reset_do_last", do_last, 0);
        chk("reset_ovf", ovf, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Single frame with latency and literal pins.
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        @(negedge clock); chk("lat_edge1", do_en, 0);
        @(negedge clock); chk("lat_edge2", do_en, 0);
        @(negedge clock);
        chk("lat_first_en", do_en, 1);
        chk("first_re", do_re, 32'h0000_0000);
        chk("first_im", do_im, 32'hFFFF_FFFF);
        chk("first_idx", do_idx, 0);
        chk("first_last", do_last, 0);
        repeat (255) @(negedge clock);
        chk("last_idx", do_idx, 255);
        chk("last_re", do_re, 32'h0000_00FF);
        chk("last_im", do_im, 32'hFFFF_FF00);
        chk("last_flag", do_last, 1);
        @(negedge clock); chk("after_last_en", do_en, 0);
        drain("drain_single");

        // Four back-to-back frames.
        max_run = 0;
        cur_run = 0;
        for (int t = 0; t < 4; t++) send_frame(8'(t), 1'b0, 1'b1, 1'b0);
        drain("drain_cont");
        chk("cont_run", max_run, 1024);
        chk("cont_ovf", ovf, 0);

        // Input gaps with random backpressure.
        rdy_mode = 2;
        for (int t = 4; t < 7; t++) send_frame(8'(t), 1'b1, 1'b1, 1'b0);
        drain("drain_gaps");
        rdy_mode = 1;
        chk("gaps_ovf", ovf, 0);

        // Overflow: third frame dropped while output is stalled; clear loses to drop.
        rdy_mode = 0;
        send_frame(8'd10, 1'b0, 1'b1, 1'b0);
        send_frame(8'd11, 1'b0, 1'b1, 1'b0);
        send_frame(8'd12, 1'b0, 1'b0, 1'b1);
        @(negedge clock); chk("ovf_set", ovf, 1);
        rdy_mode = 1;
        drain("drain_ovf");
        send_frame(8'd13, 1'b0, 1'b1, 1'b0);
        drain("drain_after_ovf");
        chk("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        @(posedge clock); #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // New frame starts on the edge of the do_last handshake of its bank.
        send_frame(8'd20, 1'b0, 1'b1, 1'b0);
        send_frame(8'd21, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("bnd_last_now", do_last, 1);
        send_frame(8'd22, 1'b0, 1'b1, 1'b0);
        drain("drain_bnd");
        chk("bnd_ovf", ovf, 0);

        // Reset during input sample 100.
        for (int j = 0; j < 100; j++) begin
            di_en = 1'b1;
            di_re = 32'(j);
            di_im = '1;
            @(posedge clock); #1;
        end
        apply_reset("rst_in");
        send_frame(8'd30, 1'b0, 1'b1, 1'b0);
        drain("drain_rst_in");

        // Reset while bin 40 is on the output.
        send_frame(8'd31, 1'b0, 1'b1, 1'b0);
        begin
            int n = 0;
            while (!(do_en && do_idx == 8'd40) && n < 1000) begin
                @(negedge clock);
                n++;
            end
        end
        chk("reach_bin40", do_idx, 40);
        #1;
        apply_reset("rst_out");
        send_frame(8'd32, 1'b0, 1'b1, 1'b0);
        drain("drain_rst_out");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
